// File: rtl/des_pkg.sv
// Shared DES tables, FSM state type and bit-ordering helpers for the decrypt core.
// Bit 0 of every vector is DES bit 1; all tables hold the standard 1-based positions.
package des_pkg;

  localparam int unsigned BLK_W    = 64;
  localparam int unsigned HALF_W   = 32;
  localparam int unsigned CD_W     = 28;
  localparam int unsigned KS_W     = 56;
  localparam int unsigned SUBKEY_W = 48;
  localparam int unsigned RND_W    = 5;
  localparam int unsigned NUM_RND  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int unsigned IPI_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  // Decrypt rotates right (round 1 uses C0/D0 directly); encrypt rotates left.
  localparam int unsigned DEC_SHIFT [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int unsigned ENC_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam int unsigned SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic logic [0:BLK_W-1] perm_ip(input logic [0:BLK_W-1] x);
    logic [0:BLK_W-1] y;
    for (int i = 0; i < 64; i++) y[i] = x[6'(IP_T[i] - 1)];
    return y;
  endfunction

  function automatic logic [0:BLK_W-1] perm_ip_inv(input logic [0:BLK_W-1] x);
    logic [0:BLK_W-1] y;
    for (int i = 0; i < 64; i++) y[i] = x[6'(IPI_T[i] - 1)];
    return y;
  endfunction

  function automatic logic [0:SUBKEY_W-1] perm_e(input logic [0:HALF_W-1] x);
    logic [0:SUBKEY_W-1] y;
    for (int i = 0; i < 48; i++) y[i] = x[5'(E_T[i] - 1)];
    return y;
  endfunction

  function automatic logic [0:HALF_W-1] perm_p(input logic [0:HALF_W-1] x);
    logic [0:HALF_W-1] y;
    for (int i = 0; i < 32; i++) y[i] = x[5'(P_T[i] - 1)];
    return y;
  endfunction

  function automatic logic [0:KS_W-1] perm_pc1(input logic [0:BLK_W-1] x);
    logic [0:KS_W-1] y;
    for (int i = 0; i < 56; i++) y[i] = x[6'(PC1_T[i] - 1)];
    return y;
  endfunction

  function automatic logic [0:SUBKEY_W-1] perm_pc2(input logic [0:KS_W-1] x);
    logic [0:SUBKEY_W-1] y;
    for (int i = 0; i < 48; i++) y[i] = x[6'(PC2_T[i] - 1)];
    return y;
  endfunction

  // Row from the outer bits, column from the inner four.
  function automatic logic [3:0] sbox_lu(input logic [2:0] s, input logic [5:0] b);
    return 4'(SBOX[s][{b[5], b[0], b[4:1]}]);
  endfunction

  function automatic logic [1:0] shift_amt(input logic [RND_W-1:0] rnd, input logic enc);
    logic [3:0] idx;
    logic [1:0] amt;
    idx = 4'(rnd - 5'd1);
    amt = enc ? 2'(ENC_SHIFT[idx]) : 2'(DEC_SHIFT[idx]);
    if (rnd == '0 || rnd > 5'(NUM_RND)) amt = 2'd0;
    return amt;
  endfunction

  function automatic logic [0:CD_W-1] rot_cd(input logic [0:CD_W-1] x, input logic [1:0] amt,
                                              input logic left);
    logic [0:CD_W-1] y;
    y = x;
    if (left) begin
      if (amt == 2'd1)      y = {x[1:27], x[0]};
      else if (amt == 2'd2) y = {x[2:27], x[0:1]};
    end else begin
      if (amt == 2'd1)      y = {x[27], x[0:26]};
      else if (amt == 2'd2) y = {x[26:27], x[0:25]};
    end
    return y;
  endfunction

endpackage

// File: rtl/des_decrypt_core_key_sched_rev.sv
// Reversed on-the-fly key schedule: C/D registers loaded through PC1, rotated per round,
// with the PC2 subkey formed from the rotated value so each round's key is ready in-cycle.
module des_key_sched_rev
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic                enc,
  input  logic [0:BLK_W-1]    key,
  input  logic [RND_W-1:0]    rnd,
  output logic [0:SUBKEY_W-1] subkey_c
);

  logic [0:CD_W-1] c_q, c_d, d_q, d_d;
  logic [0:CD_W-1] c_rot, d_rot;
  logic [1:0]      amt;

  always_comb begin
    amt      = shift_amt(rnd, enc);
    c_rot    = rot_cd(c_q, amt, enc);
    d_rot    = rot_cd(d_q, amt, enc);
    subkey_c = perm_pc2({c_rot, d_rot});
    c_d      = c_q;
    d_d      = d_q;
    if (load) begin
      {c_d, d_d} = perm_pc1(key);
    end else if (step) begin
      c_d = c_rot;
      d_d = d_rot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= '0;
      d_q <= '0;
    end else begin
      c_q <= c_d;
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/f_func.sv
// DES round function: expand R, mix in the subkey, S-box substitute, P-permute.
module f_func
  import des_pkg::*;
(
  input  logic [0:HALF_W-1]   r_in,
  input  logic [0:SUBKEY_W-1] subkey,
  output logic [0:HALF_W-1]   f_c
);

  logic [0:SUBKEY_W-1] mix;
  logic [0:HALF_W-1]   sbox_out;

  always_comb begin
    mix      = perm_e(r_in) ^ subkey;
    sbox_out = '0;
    for (int s = 0; s < 8; s++) sbox_out[4*s +: 4] = sbox_lu(3'(s), mix[6*s +: 6]);
    f_c = perm_p(sbox_out);
  end

endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decrypt engine: valid/ready in, 16 rounds at one per clock, valid/ready out.
// Optional DES_DEC_ENC_MODE_EN adds an enc input that switches the schedule to encryption.
module des_decrypt_core
  import des_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:BLK_W-1] data_in,
  input  logic [0:BLK_W-1] key,
`ifdef DES_DEC_ENC_MODE_EN
  input  logic             enc,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:BLK_W-1] data_out,
  output logic             busy
);

  state_e                state_q, state_d;
  logic [RND_W-1:0]      rnd_q, rnd_d;
  logic [0:HALF_W-1]     l_q, l_d, r_q, r_d;
  logic [0:BLK_W-1]      data_out_q, data_out_d;
  logic                  ks_load, ks_step, rnd_ok, enc_mode;
  logic [0:SUBKEY_W-1]   subkey_c;
  logic [0:HALF_W-1]     f_c;

`ifdef DES_DEC_ENC_MODE_EN
  logic enc_q, enc_d;
  assign enc_mode = enc_q;
`else
  assign enc_mode = 1'b0;
`endif

  des_key_sched_rev u_key_sched (
    .clk      (clk),
    .rst      (rst),
    .load     (ks_load),
    .step     (ks_step),
    .enc      (enc_mode),
    .key      (key),
    .rnd      (rnd_q),
    .subkey_c (subkey_c)
  );

  f_func u_f_func (
    .r_in   (r_q),
    .subkey (subkey_c),
    .f_c    (f_c)
  );

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign data_out  = data_out_q;

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    rnd_d      = rnd_q;
    l_d        = l_q;
    r_d        = r_q;
    data_out_d = data_out_q;
    ks_load    = 1'b0;
    ks_step    = 1'b0;
    rnd_ok     = (rnd_q != '0) && (rnd_q <= 5'(NUM_RND));
`ifdef DES_DEC_ENC_MODE_EN
    enc_d      = enc_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          state_d    = ST_ROUND;
          {l_d, r_d} = perm_ip(data_in);
          rnd_d      = 5'd1;
          ks_load    = 1'b1;
`ifdef DES_DEC_ENC_MODE_EN
          enc_d      = enc;
`endif
        end
      end
      ST_ROUND: begin
        if (!rnd_ok) begin
          state_d = ST_IDLE;
          rnd_d   = '0;
        end else begin
          ks_step = 1'b1;
          l_d     = r_q;
          r_d     = l_q ^ f_c;
          if (rnd_q == 5'(NUM_RND)) begin
            // Final round: undo the half swap before the inverse IP.
            data_out_d = perm_ip_inv({r_d, l_d});
            state_d    = ST_DONE;
            rnd_d      = '0;
          end else begin
            rnd_d = rnd_q + 5'd1;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rnd_q      <= '0;
      l_q        <= '0;
      r_q        <= '0;
      data_out_q <= '0;
`ifdef DES_DEC_ENC_MODE_EN
      enc_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rnd_q      <= rnd_d;
      l_q        <= l_d;
      r_q        <= r_d;
      data_out_q <= data_out_d;
`ifdef DES_DEC_ENC_MODE_EN
      enc_q      <= enc_d;
`endif
    end
  end

endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed plus random bench for des_decrypt_core against a precomputed-subkey DES model.
module tb_des_decrypt_core;
  import des_pkg::*;

  localparam logic [0:63] V1_KEY = 64'h133457799BBCDFF1;
  localparam logic [0:63] V1_CT  = 64'h85E813540F0AB405;
  localparam logic [0:63] V1_PT  = 64'h0123456789ABCDEF;
  localparam logic [0:63] V2_KEY = 64'h0E329232EA6D0D73;
  localparam logic [0:63] V2_CT  = 64'h0000000000000000;
  localparam logic [0:63] V2_PT  = 64'h8787878787878787;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, in_ready, out_valid, busy;
  logic [0:63] data_in, key, data_out;
`ifdef DES_DEC_ENC_MODE_EN
  logic        enc;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int acc_cyc[$];
  logic [0:63] outs[$];

  des_decrypt_core dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .key       (key),
`ifdef DES_DEC_ENC_MODE_EN
    .enc       (enc),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Record the cycle of every input handshake and the data of every output handshake.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && in_valid && in_ready) acc_cyc.push_back(cyc);
    if (!rst && out_valid && out_ready) outs.push_back(data_out);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  function automatic logic [0:31] ref_f(input logic [0:31] r, input logic [0:47] k);
    logic [0:47] x;
    logic [0:31] s_out, p;
    int row, col, v;
    for (int i = 0; i < 48; i++) x[i] = r[E_T[i] - 1] ^ k[i];
    for (int s = 0; s < 8; s++) begin
      row = 2 * int'(x[6*s]) + int'(x[6*s+5]);
      col = 8 * int'(x[6*s+1]) + 4 * int'(x[6*s+2]) + 2 * int'(x[6*s+3]) + int'(x[6*s+4]);
      v   = int'(SBOX[s][16*row + col]);
      for (int b = 0; b < 4; b++) s_out[4*s + b] = v[3-b];
    end
    for (int i = 0; i < 32; i++) p[i] = s_out[P_T[i] - 1];
    return p;
  endfunction

  // Textbook DES: build K1..K16 by left shifts, then apply in forward or reverse order.
  function automatic logic [0:63] des_ref(input logic [0:63] blk, input logic [0:63] k,
                                          input bit encrypt);
    int          sh[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    logic [0:55] cd;
    logic [0:27] c, d;
    logic [0:47] sk[16];
    logic [0:63] t, o;
    logic [0:31] l, r, tmp;
    for (int i = 0; i < 56; i++) cd[i] = k[PC1_T[i] - 1];
    c = cd[0:27];
    d = cd[28:55];
    for (int rd = 0; rd < 16; rd++) begin
      for (int s = 0; s < sh[rd]; s++) begin
        c = {c[1:27], c[0]};
        d = {d[1:27], d[0]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) sk[rd][i] = cd[PC2_T[i] - 1];
    end
    for (int i = 0; i < 64; i++) t[i] = blk[IP_T[i] - 1];
    l = t[0:31];
    r = t[32:63];
    for (int rd = 0; rd < 16; rd++) begin
      tmp = r;
      r   = l ^ ref_f(r, encrypt ? sk[rd] : sk[15 - rd]);
      l   = tmp;
    end
    t = {r, l};
    for (int i = 0; i < 64; i++) o[i] = t[IPI_T[i] - 1];
    return o;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge just after the accept edge.
  task automatic do_accept(input string tag, input logic [0:63] ct, input logic [0:63] k);
    int guard;
    in_valid = 1'b1;
    data_in  = ct;
    key      = k;
    guard    = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " accept"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    data_in  = {$urandom, $urandom};
    key      = {$urandom, $urandom};
  endtask

  task automatic run_block(input string tag, input logic [0:63] ct, input logic [0:63] k,
                           input logic [0:63] exp, output logic [0:63] got);
    int edges;
`ifdef DES_DEC_ENC_MODE_EN
    logic enc_keep;
    enc_keep = enc;
`endif
    do_accept(tag, ct, k);
`ifdef DES_DEC_ENC_MODE_EN
    enc = 1'($urandom_range(0, 1));
`endif
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check({tag, " latency"}, 64'(edges), 64'd16);
    check({tag, " data"}, data_out, exp);
    check({tag, " ready_low"}, 64'(in_ready), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd1);
    got       = data_out;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, " idle"}, 64'(in_ready), 64'd1);
`ifdef DES_DEC_ENC_MODE_EN
    enc = enc_keep;
`endif
  endtask

  logic [0:63] got, got2, hold, k2, p;
  logic [0:63] bk[4], bc[4], bp[4];
  logic [7:0]  mask;
  int          guard, nacc, base, obase;
  bit          seen;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    data_in   = V1_CT;
    key       = V1_KEY;
`ifdef DES_DEC_ENC_MODE_EN
    enc       = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst in_ready", 64'(in_ready), 64'd0);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst data_out", data_out, 64'd0);
    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    check("post-rst in_ready", 64'(in_ready), 64'd1);
    check("post-rst accepts", 64'(acc_cyc.size()), 64'd0);

    run_block("v1", V1_CT, V1_KEY, V1_PT, got);
    run_block("v2", V2_CT, V2_KEY, V2_PT, got);
    for (int n = 0; n < 2; n++) begin
      mask = 8'($urandom_range(1, 255));
      k2   = V2_KEY;
      for (int j = 0; j < 8; j++) if (mask[j]) k2[8*j + 7] = ~k2[8*j + 7];
      run_block("v2 parity", V2_CT, k2, V2_PT, got);
    end

    // Output backpressure with a competing input request.
    do_accept("bp", V1_CT, V1_KEY);
    guard = 0;
    while (!out_valid && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    hold = data_out;
    check("bp data", hold, V1_PT);
    nacc     = acc_cyc.size();
    in_valid = 1'b1;
    data_in  = {$urandom, $urandom};
    key      = {$urandom, $urandom};
    repeat (50) begin
      @(negedge clk);
      check("bp hold", data_out, hold);
      check("bp ready", 64'(in_ready), 64'd0);
    end
    check("bp no accept", 64'(acc_cyc.size()), 64'(nacc));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp idle busy", 64'(busy), 64'd0);
    check("bp idle ready", 64'(in_ready), 64'd1);

    // Reset during round 8 abandons the block.
    do_accept("mid", V1_CT, V1_KEY);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("mid no output", 64'(seen), 64'd0);
    check("mid data_out", data_out, 64'd0);
    check("mid busy", 64'(busy), 64'd0);
    run_block("mid v1", V1_CT, V1_KEY, V1_PT, got);

    // Back-to-back random blocks with both handshakes held open.
    for (int i = 0; i < 4; i++) begin
      bk[i] = {$urandom, $urandom};
      bc[i] = {$urandom, $urandom};
      bp[i] = des_ref(bc[i], bk[i], 1'b0);
    end
    base      = acc_cyc.size();
    obase     = outs.size();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = bc[0];
    key       = bk[0];
    for (int i = 0; i < 4; i++) begin
      guard = 0;
      while (acc_cyc.size() <= base + i && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (i < 3) begin
        data_in = bc[i+1];
        key     = bk[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    guard = 0;
    while (outs.size() < obase + 4 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    check("b2b count", 64'(outs.size()), 64'(obase + 4));
    for (int i = 0; i < 4; i++) check($sformatf("b2b data%0d", i), outs[obase + i], bp[i]);
    for (int i = 0; i < 3; i++)
      check($sformatf("b2b spacing%0d", i), 64'(acc_cyc[base+i+1] - acc_cyc[base+i]), 64'd18);
    @(negedge clk);

`ifdef DES_DEC_ENC_MODE_EN
    enc = 1'b1;
    run_block("enc kat", V1_PT, V1_KEY, V1_CT, got);
    p  = {$urandom, $urandom};
    k2 = {$urandom, $urandom};
    run_block("rt enc", p, k2, des_ref(p, k2, 1'b1), got);
    enc = 1'b0;
    run_block("rt dec", got, k2, p, got2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
